// File: rtl/spi_stream_scheduler.sv
// Arbitrates the shared SPI acquisition link between audio refill and video bank fill.
// Audio normally wins, with bounded video starvation, a burst watchdog and an inter-burst gap.
module spi_stream_scheduler #(
  parameter int AUD_LVL_W      = 10,
  parameter int AUD_LOW_WM     = 256,
  parameter int AUD_CRIT_WM    = 64,
  parameter int MAX_AUD_CONSEC = 2,
  parameter int AUD_BURST_BITS = 2048,
  parameter int VID_BURST_BITS = 480000,
  parameter int LEN_W          = 19,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1 << 22
) (
  input  logic                 CLK_40,
  input  logic                 reset,
  input  logic                 vid_req,
  input  logic [AUD_LVL_W-1:0] aud_level,
  input  logic                 pause_en,
  input  logic                 xfer_done,
  output logic                 start_req,
  output logic                 xfer_is_audio,
  output logic [LEN_W-1:0]     xfer_len,
  output logic                 vid_grant,
  output logic                 aud_grant,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CON_W = $clog2(MAX_AUD_CONSEC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t             r_state;
  logic               r_start_req, r_vid_grant, r_aud_grant, r_busy, r_timeout_err, r_is_audio;
  logic [LEN_W-1:0]   r_len;
  logic [TMR_W-1:0]   r_timer;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [CON_W-1:0]   r_aud_consec;

  logic w_aud_need, w_aud_crit, w_pick_aud, w_pick_vid;

  assign w_aud_need = aud_level < AUD_LVL_W'(AUD_LOW_WM);
  assign w_aud_crit = aud_level < AUD_LVL_W'(AUD_CRIT_WM);

  // Video wins a contested slot only once audio has used up its consecutive allowance.
  always_comb begin
    w_pick_aud = 1'b0;
    w_pick_vid = 1'b0;
    if (w_aud_crit)
      w_pick_aud = 1'b1;
    else if (w_aud_need && vid_req) begin
      if (r_aud_consec < CON_W'(MAX_AUD_CONSEC)) w_pick_aud = 1'b1;
      else                                        w_pick_vid = 1'b1;
    end
    else if (w_aud_need)
      w_pick_aud = 1'b1;
    else if (vid_req)
      w_pick_vid = 1'b1;
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_state       <= IDLE;
      r_start_req   <= 1'b0;
      r_vid_grant   <= 1'b0;
      r_aud_grant   <= 1'b0;
      r_busy        <= 1'b0;
      r_is_audio    <= 1'b0;
      r_len         <= '0;
      r_timeout_err <= 1'b0;
      r_aud_consec  <= '0;
      r_timer       <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_start_req <= 1'b0;
      r_vid_grant <= 1'b0;
      r_aud_grant <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!pause_en && (w_pick_aud || w_pick_vid)) begin
            r_state     <= ISSUE;
            r_start_req <= 1'b1;
            r_aud_grant <= w_pick_aud;
            r_vid_grant <= w_pick_vid;
            r_is_audio  <= w_pick_aud;
            r_len       <= w_pick_aud ? LEN_W'(AUD_BURST_BITS) : LEN_W'(VID_BURST_BITS);
            r_busy      <= 1'b1;
            // Only audio grants that actually held off a waiting video count toward starvation.
            if (w_pick_aud && vid_req) begin
              if (r_aud_consec != CON_W'(MAX_AUD_CONSEC)) r_aud_consec <= r_aud_consec + 1'b1;
            end else
              r_aud_consec <= '0;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_timer <= '0;
        end
        WAIT: begin
          if (xfer_done) begin
            r_state   <= GAP;
            r_gap_cnt <= '0;
          end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            r_state       <= GAP;
            r_gap_cnt     <= '0;
            r_timeout_err <= 1'b1;
          end else
            r_timer <= r_timer + 1'b1;
        end
        GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_req     = r_start_req;
  assign vid_grant     = r_vid_grant;
  assign aud_grant     = r_aud_grant;
  assign busy          = r_busy;
  assign xfer_is_audio = r_is_audio;
  assign xfer_len      = r_len;
  assign timeout_err   = r_timeout_err;
endmodule

// File: tb/tb_spi_stream_scheduler.sv
// Directed bench for spi_stream_scheduler: an arbitration model queues the expected
// stream of each grant, popped and compared when start_req appears.
module tb_spi_stream_scheduler;
  localparam int T = 200;
  localparam int G = 16;

  logic        CLK_40 = 1'b0;
  logic        reset, vid_req, pause_en, xfer_done;
  logic [9:0]  aud_level;
  logic        start_req, xfer_is_audio, vid_grant, aud_grant, busy, timeout_err;
  logic [18:0] xfer_len;

  int nerr = 0;
  int nchk = 0;
  int exp_q[$];
  int consec_m = 0;

  spi_stream_scheduler #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
    .CLK_40(CLK_40), .reset(reset), .vid_req(vid_req), .aud_level(aud_level),
    .pause_en(pause_en), .xfer_done(xfer_done), .start_req(start_req),
    .xfer_is_audio(xfer_is_audio), .xfer_len(xfer_len), .vid_grant(vid_grant),
    .aud_grant(aud_grant), .busy(busy), .timeout_err(timeout_err));

  always #12 CLK_40 = ~CLK_40;

  task automatic step();
    @(posedge CLK_40);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 1 = audio, 0 = video, -1 = no grant
  function automatic int decide(input bit v, input int lvl, input int c);
    if (lvl < 64) return 1;
    if (lvl < 256 && v) return (c < 2) ? 1 : 0;
    if (lvl < 256) return 1;
    if (v) return 0;
    return -1;
  endfunction

  task automatic push_exp();
    int d;
    d = decide(vid_req, int'(aud_level), consec_m);
    exp_q.push_back(d);
    if (d == 1 && vid_req) consec_m = (consec_m < 2) ? consec_m + 1 : 2;
    else consec_m = 0;
  endtask

  task automatic wait_start(input string tag, input int bound, output int lat);
    int e;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!start_req && lat < bound);
    chk({tag, "_start"}, start_req, 1);
    if (start_req) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk({tag, "_aud_grant"}, aud_grant, (e == 1) ? 1 : 0);
      chk({tag, "_vid_grant"}, vid_grant, (e == 0) ? 1 : 0);
      chk({tag, "_is_audio"}, xfer_is_audio, (e == 1) ? 1 : 0);
      chk({tag, "_len"}, xfer_len, (e == 1) ? 2048 : 480000);
      chk({tag, "_busy"}, busy, 1);
    end
  endtask

  // From the ISSUE cycle: one WAIT cycle with xfer_done, then verify the gap length.
  task automatic finish_burst(input string tag);
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    repeat (G - 1) step();
    chk({tag, "_gap_busy"}, busy, 1);
    step();
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int lat;
    int cnt;
    reset = 1'b1; vid_req = 1'b0; pause_en = 1'b0; xfer_done = 1'b0; aud_level = 10'd500;
    repeat (3) step();
    chk("rst_start", start_req, 0);
    chk("rst_grants", {vid_grant, aud_grant}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_is_audio", xfer_is_audio, 0);
    chk("rst_len", xfer_len, 0);
    chk("rst_terr", timeout_err, 0);

    // Video only
    reset = 1'b0; vid_req = 1'b1; aud_level = 10'd500;
    push_exp();
    wait_start("vid1", 4, lat);
    chk("vid1_lat", lat, 1);
    vid_req = 1'b0;
    finish_burst("vid1");
    cnt = 0;
    repeat (5) begin step(); cnt += start_req; end
    chk("no_req_idle", cnt, 0);

    // Contested, audio needy: A A V A A V
    vid_req = 1'b1; aud_level = 10'd100;
    for (int i = 0; i < 6; i++) begin
      push_exp();
      wait_start($sformatf("mix%0d", i), 4, lat);
      chk($sformatf("mix%0d_lat", i), lat, 1);
      finish_burst($sformatf("mix%0d", i));
    end

    // Audio critical, then back to merely needy
    aud_level = 10'd30;
    for (int i = 0; i < 4; i++) begin
      push_exp();
      wait_start($sformatf("crit%0d", i), 4, lat);
      finish_burst($sformatf("crit%0d", i));
    end
    aud_level = 10'd100;
    for (int i = 0; i < 3; i++) begin
      push_exp();
      wait_start($sformatf("rec%0d", i), 4, lat);
      finish_burst($sformatf("rec%0d", i));
    end

    // Pause holds off grants, but not an in-flight burst
    pause_en = 1'b1; aud_level = 10'd500; vid_req = 1'b1;
    cnt = 0;
    repeat (1000) begin step(); cnt += start_req; end
    chk("pause_no_start", cnt, 0);
    chk("pause_busy", busy, 0);
    pause_en = 1'b0;
    push_exp();
    wait_start("unpause", 4, lat);
    chk("unpause_lat", lat, 1);
    vid_req = 1'b0;
    step();
    pause_en = 1'b1;
    repeat (3) step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    repeat (G - 1) step();
    chk("pwait_gap_busy", busy, 1);
    step();
    chk("pwait_idle_busy", busy, 0);
    chk("pwait_terr", timeout_err, 0);
    pause_en = 1'b0;

    // Timeout: request retained, regranted after the gap
    vid_req = 1'b1;
    push_exp();
    wait_start("to", 4, lat);
    step();
    repeat (T - 1) step();
    chk("to_before", timeout_err, 0);
    step();
    chk("to_set", timeout_err, 1);
    push_exp();
    wait_start("to_regrant", 30, lat);
    chk("to_regrant_lat", lat, G + 1);
    vid_req = 1'b0;
    chk("to_sticky", timeout_err, 1);
    finish_burst("to_regrant");
    reset = 1'b1;
    step();
    reset = 1'b0;
    consec_m = 0;
    chk("to_cleared", timeout_err, 0);

    // Done on the terminal count wins over timeout
    vid_req = 1'b1;
    push_exp();
    wait_start("tie", 4, lat);
    vid_req = 1'b0;
    step();
    repeat (T - 1) step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("tie_terr", timeout_err, 0);
    repeat (G - 1) step();
    chk("tie_gap_busy", busy, 1);
    step();
    chk("tie_idle_busy", busy, 0);
    chk("tie_terr_end", timeout_err, 0);

    // Reset mid-burst, then a stray xfer_done in IDLE
    vid_req = 1'b1;
    push_exp();
    wait_start("rmid", 4, lat);
    step();
    reset = 1'b1;
    step();
    chk("rmid_start", start_req, 0);
    chk("rmid_grants", {vid_grant, aud_grant}, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_len", xfer_len, 0);
    chk("rmid_is_audio", xfer_is_audio, 0);
    step();
    chk("rmid_held_start", start_req, 0);
    reset = 1'b0; vid_req = 1'b0;
    consec_m = 0;
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    cnt = 0;
    repeat (5) begin step(); cnt += start_req + busy; end
    chk("stray_done", cnt, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
